// File: rtl/td_detect_pkg.sv
// ---------------------------------------------------------------------------
// td_detect_pkg: shared types and default windows for the TV format detector.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package td_detect_pkg;

  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_NTSC = 2'd1,
    FMT_PAL  = 2'd2
  } fmt_t;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam int LCNT_W_DEF        = 10;
  localparam int STABLE_FIELDS_DEF = 4;
  localparam int NTSC_MIN_DEF      = 258;
  localparam int NTSC_MAX_DEF      = 266;
  localparam int PAL_MIN_DEF       = 308;
  localparam int PAL_MAX_DEF       = 316;
  localparam int HS_TIMEOUT_DEF    = 4096;
  localparam int HPER_W_DEF        = 16;
  localparam int HPER_MIN_DEF      = 1500;
  localparam int HPER_MAX_DEF      = 1800;

endpackage

`default_nettype wire

// File: rtl/td_sync_edge.sv
// ---------------------------------------------------------------------------
// td_sync_edge: 2-FF synchroniser with single-cycle rise pulse.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module td_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  // Decoded from the second and third stages only, so the pulse is glitch-free;
  // the consumer registers its effect, giving the third-edge output latency.
  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

`default_nettype wire

// File: rtl/td_format_detect.sv
// ---------------------------------------------------------------------------
// td_format_detect: NTSC/PAL field classifier with lock, loss and change flags.
// Rev 1.0. Optional line-period qualification: define TD_DETECT_HPERIOD_EN.
// ---------------------------------------------------------------------------
`default_nettype none

module td_format_detect
  import td_detect_pkg::*;
#(
  parameter int LCNT_W        = LCNT_W_DEF,
  parameter int STABLE_FIELDS = STABLE_FIELDS_DEF,
  parameter int NTSC_MIN      = NTSC_MIN_DEF,
  parameter int NTSC_MAX      = NTSC_MAX_DEF,
  parameter int PAL_MIN       = PAL_MIN_DEF,
  parameter int PAL_MAX       = PAL_MAX_DEF,
  parameter int HS_TIMEOUT    = HS_TIMEOUT_DEF,
  parameter int HPER_W        = HPER_W_DEF,
  parameter int HPER_MIN      = HPER_MIN_DEF,
  parameter int HPER_MAX      = HPER_MAX_DEF
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iTD_HS,
  input  logic              iTD_VS,
  output logic              oTD_Stable,
  output logic              oNTSC,
  output logic              oPAL,
  output logic [LCNT_W-1:0] oLines,
  output logic [HPER_W-1:0] oLine_Period,
  output logic              oFmt_Change
);

  localparam int c_idle_w = $clog2(HS_TIMEOUT + 1);

  localparam logic [LCNT_W-1:0]   c_lmax     = '1;
  localparam logic [LCNT_W-1:0]   c_ntsc_min = LCNT_W'(NTSC_MIN);
  localparam logic [LCNT_W-1:0]   c_ntsc_max = LCNT_W'(NTSC_MAX);
  localparam logic [LCNT_W-1:0]   c_pal_min  = LCNT_W'(PAL_MIN);
  localparam logic [LCNT_W-1:0]   c_pal_max  = LCNT_W'(PAL_MAX);
  localparam logic [c_idle_w-1:0] c_timeout  = c_idle_w'(HS_TIMEOUT);
  localparam logic [3:0]          c_stable   = 4'(STABLE_FIELDS);

  if (STABLE_FIELDS < 1 || STABLE_FIELDS > 15 || NTSC_MIN > NTSC_MAX ||
      PAL_MIN > PAL_MAX || HPER_MIN > HPER_MAX) begin : g_cfg_check
    $error("td_format_detect: invalid parameter set");
  end

  logic w_hs_rise;
  logic w_vs_rise;

  td_sync_edge u_hs_sync (
    .clk_i   (iCLK),
    .rst_ni  (iRST_N),
    .async_i (iTD_HS),
    .rise_o  (w_hs_rise)
  );

  td_sync_edge u_vs_sync (
    .clk_i   (iCLK),
    .rst_ni  (iRST_N),
    .async_i (iTD_VS),
    .rise_o  (w_vs_rise)
  );

  state_t                state_q,    state_d;
  fmt_t                  class_q,    class_d;
  logic [LCNT_W-1:0]     line_cnt_q, line_cnt_d;
  logic [LCNT_W-1:0]     lines_q,    lines_d;
  logic [c_idle_w-1:0]   idle_q,     idle_d;
  logic [3:0]            match_q,    match_d;
  logic                  stable_q,   stable_d;
  logic                  chg_q,      chg_d;

  logic [LCNT_W-1:0]     w_field;
  fmt_t                  w_cls;
  logic [3:0]            w_match;
  logic                  w_loss;
  logic                  w_per_ok;

  // An HS landing on the VS cycle belongs to the field that is ending.
  assign w_field = (w_hs_rise && (line_cnt_q != c_lmax)) ? line_cnt_q + LCNT_W'(1) : line_cnt_q;

  assign w_loss = (idle_q == c_timeout) || ((line_cnt_q == c_lmax) && !w_vs_rise);

`ifdef TD_DETECT_HPERIOD_EN
  logic [HPER_W-1:0] per_cnt_q, per_cnt_d;
  logic [HPER_W-1:0] period_q,  period_d;
  logic              bad_q,     bad_d;
  logic [HPER_W-1:0] w_per;
  logic              w_per_bad;

  localparam logic [HPER_W-1:0] c_hper_min = HPER_W'(HPER_MIN);
  localparam logic [HPER_W-1:0] c_hper_max = HPER_W'(HPER_MAX);

  assign w_per     = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + HPER_W'(1);
  assign w_per_bad = w_hs_rise && ((w_per < c_hper_min) || (w_per > c_hper_max));
  assign w_per_ok  = !(bad_q || w_per_bad);

  always_comb begin
    per_cnt_d = w_hs_rise ? '0 : w_per;
    period_d  = w_hs_rise ? w_per : period_q;
    bad_d     = bad_q | w_per_bad;
    if (w_vs_rise || w_loss || (state_q == ST_SEARCH)) begin
      bad_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      per_cnt_q <= '0;
      period_q  <= '0;
      bad_q     <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
      bad_q     <= bad_d;
    end
  end

  assign oLine_Period = period_q;
`else
  assign w_per_ok     = 1'b1;
  assign oLine_Period = '0;
`endif

  always_comb begin
    idle_d = idle_q;
    if (w_hs_rise) begin
      idle_d = '0;
    end else if (idle_q != c_timeout) begin
      idle_d = idle_q + c_idle_w'(1);
    end
  end

  always_comb begin
    w_cls = FMT_NONE;
    if (w_per_ok) begin
      if ((w_field >= c_ntsc_min) && (w_field <= c_ntsc_max)) begin
        w_cls = FMT_NTSC;
      end else if ((w_field >= c_pal_min) && (w_field <= c_pal_max)) begin
        w_cls = FMT_PAL;
      end
    end
  end

  always_comb begin
    w_match = 4'd0;
    if (w_cls != FMT_NONE) begin
      if (w_cls != class_q) begin
        w_match = 4'd1;
      end else if (match_q >= c_stable) begin
        w_match = c_stable;
      end else begin
        w_match = match_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    line_cnt_d = line_cnt_q;
    lines_d    = lines_q;
    match_d    = match_q;
    stable_d   = stable_q;
    chg_d      = 1'b0;
    if (w_loss) begin
      // Loss overrides a coincident VS: that field is discarded, oLines holds.
      state_d    = ST_SEARCH;
      class_d    = FMT_NONE;
      line_cnt_d = '0;
      match_d    = 4'd0;
      stable_d   = 1'b0;
      chg_d      = (class_q != FMT_NONE);
    end else begin
      case (state_q)
        ST_SEARCH: begin
          line_cnt_d = '0;
          if (w_vs_rise) begin
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (w_vs_rise) begin
            line_cnt_d = '0;
            lines_d    = w_field;
            class_d    = w_cls;
            match_d    = w_match;
            stable_d   = (w_match == c_stable) && (w_cls != FMT_NONE);
            chg_d      = (w_cls != class_q);
            state_d    = stable_d ? ST_LOCKED : ST_MEASURE;
          end else if (w_hs_rise && (line_cnt_q != c_lmax)) begin
            line_cnt_d = line_cnt_q + LCNT_W'(1);
          end
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_SEARCH;
      class_q    <= FMT_NONE;
      line_cnt_q <= '0;
      lines_q    <= '0;
      idle_q     <= '0;
      match_q    <= 4'd0;
      stable_q   <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      line_cnt_q <= line_cnt_d;
      lines_q    <= lines_d;
      idle_q     <= idle_d;
      match_q    <= match_d;
      stable_q   <= stable_d;
      chg_q      <= chg_d;
    end
  end

  assign oTD_Stable  = stable_q;
  assign oNTSC       = (class_q == FMT_NTSC);
  assign oPAL        = (class_q == FMT_PAL);
  assign oLines      = lines_q;
  assign oFmt_Change = chg_q;

endmodule

`default_nettype wire

// File: tb/tb_td_format_detect.sv
// ---------------------------------------------------------------------------
// tb_td_format_detect: field-level reference model bench for td_format_detect.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_td_format_detect;

  localparam int LCNT_W     = 6;
  localparam int STABLE     = 4;
  localparam int NTSC_MIN   = 20;
  localparam int NTSC_MAX   = 24;
  localparam int PAL_MIN    = 28;
  localparam int PAL_MAX    = 32;
  localparam int HS_TIMEOUT = 64;
  localparam int HPER_W     = 8;
  localparam int HPER_MIN   = 10;
  localparam int HPER_MAX   = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              hs;
  logic              vs;
  logic              stable;
  logic              ntsc;
  logic              pal;
  logic [LCNT_W-1:0] lines;
  logic [HPER_W-1:0] lper;
  logic              chg;

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int chg_cnt = 0;
  int chg_base = 0;

  // Reference model: one entry per classified field since the last search.
  int hist[$];
  bit m_search;
  int e_lines, e_cls, e_stable, e_per, e_chg, m_prev_per;

  td_format_detect #(
    .LCNT_W        (LCNT_W),
    .STABLE_FIELDS (STABLE),
    .NTSC_MIN      (NTSC_MIN),
    .NTSC_MAX      (NTSC_MAX),
    .PAL_MIN       (PAL_MIN),
    .PAL_MAX       (PAL_MAX),
    .HS_TIMEOUT    (HS_TIMEOUT),
    .HPER_W        (HPER_W),
    .HPER_MIN      (HPER_MIN),
    .HPER_MAX      (HPER_MAX)
  ) dut (
    .iCLK         (clk),
    .iRST_N       (rst_n),
    .iTD_HS       (hs),
    .iTD_VS       (vs),
    .oTD_Stable   (stable),
    .oNTSC        (ntsc),
    .oPAL         (pal),
    .oLines       (lines),
    .oLine_Period (lper),
    .oFmt_Change  (chg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chg === 1'b1) chg_cnt++;
  end

  function automatic bit per_bad(input int p);
    return (p < HPER_MIN) || (p > HPER_MAX);
  endfunction

  function automatic int classify(input int n, input bit qual);
    if (!qual) return 0;
    if (n >= NTSC_MIN && n <= NTSC_MAX) return 1;
    if (n >= PAL_MIN && n <= PAL_MAX) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_search   = 1'b1;
    e_lines    = 0;
    e_cls      = 0;
    e_stable   = 0;
    e_per      = 0;
    e_chg      = 0;
    m_prev_per = 0;
  endtask

  task automatic model_loss();
    e_chg    = (e_cls != 0) ? 1 : 0;
    e_cls    = 0;
    e_stable = 0;
    hist.delete();
    m_search = 1'b1;
  endtask

  task automatic model_vs(input int n, input int per);
    bit qual;
    int cls;
    int prev;
`ifdef TD_DETECT_HPERIOD_EN
    qual  = !per_bad(per) && !per_bad(m_prev_per);
    e_per = per;
`else
    qual  = 1'b1;
`endif
    if (m_search) begin
      m_search = 1'b0;
      e_chg    = 0;
    end else begin
      cls  = classify(n, qual);
      prev = (hist.size() > 0) ? hist[hist.size()-1] : 0;
      hist.push_back(cls);
      e_lines  = n;
      e_chg    = (cls != prev) ? 1 : 0;
      e_cls    = cls;
      e_stable = 0;
      if (cls != 0 && hist.size() >= STABLE) begin
        e_stable = 1;
        for (int k = 1; k <= STABLE; k++) begin
          if (hist[hist.size()-k] != cls) e_stable = 0;
        end
      end
    end
    m_prev_per = per;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " lines"},  32'(lines),  e_lines);
    chk({tag, " ntsc"},   32'(ntsc),   (e_cls == 1) ? 1 : 0);
    chk({tag, " pal"},    32'(pal),    (e_cls == 2) ? 1 : 0);
    chk({tag, " stable"}, 32'(stable), e_stable);
    chk({tag, " period"}, 32'(lper),   e_per);
    chk({tag, " fmt_change pulses"}, chg_cnt - chg_base, e_chg);
    chg_base = chg_cnt;
    e_chg    = 0;
  endtask

  task automatic step(input bit h, input bit v);
    hs = h;
    vs = v;
    @(negedge clk);
    #1;
  endtask

  // n lines of per cycles; VS rises in the last line, on its HS edge if coincide.
  task automatic run_field(input int n, input int per, input bit coincide, input string tag);
    int vs_c;
    vs_c = coincide ? 0 : int'($urandom_range(4, per - 3));
    for (int l = 0; l < n; l++) begin
      for (int c = 0; c < per; c++) begin
        step(c < 3, (l == n - 1) && (c >= vs_c));
        if (l == n - 1 && c == vs_c + 2) begin
          model_vs(n, per);
          check_all(tag);
        end
      end
    end
  endtask

  task automatic run_lines(input int n, input int per);
    for (int l = 0; l < n; l++) begin
      for (int c = 0; c < per; c++) step(c < 3, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    int kind;
    int n;
    int per;
    rst_n = 1'b0;
    hs    = 1'b0;
    vs    = 1'b0;
    model_reset();
    idle(3);
    check_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_field(22, 12, 1'b0, "ntsc");
    for (int i = 0; i < 5; i++) run_field(30, 12, 1'b0, "pal");
    run_field(26, 12, 1'b0, "none");
    for (int i = 0; i < 5; i++) run_field(22, 12, 1'b0, "recover");

    idle(40);
    check_all("idle_pre");
    idle(40);
    model_loss();
    check_all("idle_loss");

    for (int i = 0; i < 6; i++) run_field(22, 12, (i % 2) == 1, "coincident");

    run_lines(70, 12);
    model_loss();
    check_all("sat_loss");
    run_field(30, 12, 1'b0, "post_sat");

    run_lines(10, 12);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chg_base = chg_cnt;
    check_all("async_rst");
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) run_field(22, 12, 1'b1, "after_rst");

    for (int i = 0; i < 6; i++) run_field(22, 8, 1'b0, "fast_period");

    kind = 1;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) >= 7) kind = int'($urandom_range(0, 2));
      case (kind)
        1:       n = int'($urandom_range(NTSC_MIN, NTSC_MAX));
        2:       n = int'($urandom_range(PAL_MIN, PAL_MAX));
        default: n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 19)) : int'($urandom_range(33, 40));
      endcase
      if ($urandom_range(0, 9) == 0) per = ($urandom_range(0, 1) == 1) ? 16 : 8;
      else per = int'($urandom_range(HPER_MIN, HPER_MAX));
      run_field(n, per, $urandom_range(0, 3) == 0, "random");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/td_format_detect.md
# td_format_detect

Parametrised successor of the line-clocked NTSC/PAL detector in the video input path. It runs on the system clock instead of the decoder HS, and synchronises the TV decoder HS/VS. It counts lines per field, classifies the field as NTSC or PAL against configurable windows, and declares a stable lock only after a programmable number of consecutive matching fields. It detects loss of signal, flags format changes and sits between the TV decoder sync outputs and the capture/deinterlace control.

## Interface
Parameters:
- LCNT_W, 10, line counter width; count saturates at 2^LCNT_W-1
- STABLE_FIELDS, 4, consecutive identical-class fields required for lock (1..15)
- NTSC_MIN / NTSC_MAX, 258 / 266, inclusive lines-per-field window for NTSC
- PAL_MIN / PAL_MAX, 308 / 316, inclusive lines-per-field window for PAL
- HS_TIMEOUT, 4096, iCLK cycles without an HS rise that declare loss
- HPER_W, 16, line-period counter width (used only with TD_DETECT_HPERIOD_EN)
- HPER_MIN / HPER_MAX, 1500 / 1800, inclusive line-period window in iCLK cycles (used only with TD_DETECT_HPERIOD_EN)

Ports:
- iCLK  in  1  system clock; all logic on rising edge
- iRST_N  in  1  asynchronous, active-low reset
- iTD_HS  in  1  decoder HS, asynchronous to iCLK
- iTD_VS  in  1  decoder VS, asynchronous to iCLK
- oTD_Stable  out  1  lock achieved and class is NTSC or PAL
- oNTSC  out  1  last completed field classified NTSC
- oPAL  out  1  last completed field classified PAL
- oLines  out  LCNT_W  line count of last completed field
- oLine_Period  out  HPER_W  last measured HS period in iCLK cycles
- oFmt_Change  out  1  one-cycle pulse when the class differs from the previous field's class

## Operation
- HS and VS each pass through a 2-FF synchroniser and rise detector. hs_rise and vs_rise are single-cycle pulses.
- Line counter: +1 per hs_rise, saturating.
- On vs_rise:
  - the field count is the counter value plus hs_rise of the same cycle;
  - the field count is latched into oLines;
  - the counter restarts at 0.
- Class per field:
  - NTSC if the count is in [NTSC_MIN, NTSC_MAX];
  - PAL if it is in [PAL_MIN, PAL_MAX];
  - otherwise NONE.
  - oNTSC and oPAL are mutually exclusive.
- Match counter, updated on vs_rise, saturating at STABLE_FIELDS:
  - class == previous class and class != NONE: +1;
  - class changed and class != NONE: set to 1;
  - class is NONE: set to 0.
- oTD_Stable = (match counter == STABLE_FIELDS) and class != NONE.
- oFmt_Change pulses on a vs_rise whose class differs from the previous class. Transitions to and from NONE count as changes.
- FSM states:
  - SEARCH: after reset or loss. The counter is held at 0. The first vs_rise moves to MEASURE without classifying, because the first field is partial.
  - MEASURE: classify fields; go to LOCKED when oTD_Stable asserts.
  - LOCKED: any non-matching field returns to MEASURE with the match counter set per the rules above.
- Loss is declared in any state when the HS idle counter reaches HS_TIMEOUT, or when the line counter saturates without a vs_rise. On loss:
  - go to SEARCH in the next cycle;
  - class becomes NONE, oTD_Stable, oNTSC and oPAL go to 0, and the match counter goes to 0;
  - oLines holds its value;
  - oFmt_Change pulses if the previous class was not NONE.

## Timing
- Reset values: all outputs 0, FSM in SEARCH, all counters 0.
- An input edge becomes visible on outputs at the 3rd iCLK rising edge after the edge: two synchroniser stages plus one output register.
- A vs_rise and hs_rise in the same cycle: the HS is counted into the ending field.
- A vs_rise in the same cycle as loss detection: loss wins and the field is discarded.
- HS idle counter: cleared on hs_rise and saturates at HS_TIMEOUT. Loss asserts in the cycle it reaches HS_TIMEOUT.
- Reset mid-field: everything clears immediately. Lock requires 1 partial field plus STABLE_FIELDS full fields after reset.

## Configuration
- TD_DETECT_HPERIOD_EN defined:
  - the line-period counter runs, capturing cycles between hs_rise pulses into oLine_Period;
  - a field is classified NTSC or PAL only if every line period in it was within [HPER_MIN, HPER_MAX]; otherwise the class is NONE.
- TD_DETECT_HPERIOD_EN undefined:
  - no period logic is built;
  - oLine_Period is tied to 0;
  - classification uses line count only.

## Structure
- Package td_detect_pkg holds:
  - enum fmt_t {FMT_NONE, FMT_NTSC, FMT_PAL};
  - FSM state enum {ST_SEARCH, ST_MEASURE, ST_LOCKED};
  - default window constants.
- One sub-module, td_sync_edge (2-FF synchroniser plus registered rise pulse, async active-low reset), instantiated for HS and for VS.

## Test plan
- Reset, then 6 fields of 262 lines (HS period 1600 clk) -> first field unclassified; oNTSC=1 and oLines=262 after the 2nd VS; oTD_Stable=1 after the 5th VS (STABLE_FIELDS=4); oFmt_Change pulses once, at the 2nd VS.
- Locked NTSC, then switch to 312-line fields -> oFmt_Change pulse and oTD_Stable=0 at the first PAL VS; oPAL=1; oTD_Stable=1 after 4 PAL fields.
- Locked, then a single 290-line field -> oNTSC=oPAL=0, oTD_Stable=0, oFmt_Change pulse; recovery to lock after 4 good fields.
- Locked, HS held low for 4096 clk -> loss within 1 cycle: all flags 0, FSM in SEARCH, oLines held.
- VS rise coincident with HS rise on the 262nd line -> oLines=262; the next field starts at 0.
- With TD_DETECT_HPERIOD_EN, 262-line fields at HS period 1000 clk -> oLine_Period=1000, class NONE, oTD_Stable=0. Without the macro -> NTSC lock and oLine_Period=0.
